// File: rtl/matmul_sequencer.sv
// Control sequencer for an N x N matrix multiply on a single MAC unit.
// Walks C[i][j] in row-major order; every output is driven from a flop.
module matmul_sequencer #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic [IW-1:0] mux_select1,
    output logic [IW-1:0] mux_select2,
    output logic [IW-1:0] row_idx,
    output logic [IW-1:0] col_idx,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          output_set,
    output logic          output_clr,
    output logic          mem_clr,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {StIdle, StMclr, StAclr, StMac, StWrite, StFin} state_e;

    localparam logic [IW-1:0] Last = IW'(N - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        unique case (state_q)
            StIdle: begin
                i_d = '0;
                j_d = '0;
                k_d = '0;
                if (start) state_d = StMclr;
            end
            StMclr: begin
                i_d     = '0;
                j_d     = '0;
                state_d = StAclr;
            end
            StAclr: begin
                k_d     = '0;
                state_d = StMac;
            end
            StMac: begin
                if (k_q == Last) begin
                    k_d     = '0;
                    state_d = StWrite;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StWrite: begin
                if (j_q != Last) begin
                    j_d     = j_q + 1'b1;
                    state_d = StAclr;
                end else if (i_q != Last) begin
                    j_d     = '0;
                    i_d     = i_q + 1'b1;
                    state_d = StAclr;
                end else begin
                    state_d = StFin;
                end
            end
            StFin: begin
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Abort beats every other transition once a run is under way.
        if (abort && state_q != StIdle) begin
            state_d = StIdle;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            mux_select1 <= '0;
            mux_select2 <= '0;
            row_idx     <= '0;
            col_idx     <= '0;
            acc_clr     <= 1'b0;
            acc_en      <= 1'b0;
            output_set  <= 1'b0;
            output_clr  <= 1'b0;
            mem_clr     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            mux_select1 <= (state_d == StMac) ? k_d : '0;
            mux_select2 <= (state_d == StMac) ? k_d : '0;
            row_idx     <= i_d;
            col_idx     <= j_d;
            acc_clr     <= (state_d == StAclr);
            acc_en      <= (state_d == StMac);
            output_set  <= (state_d == StWrite);
            output_clr  <= abort && (state_q != StIdle);
            mem_clr     <= (state_d == StMclr);
            busy        <= (state_d != StIdle);
            done        <= (state_d == StFin);
        end
    end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameter N, default 3, SHALL set the square matrix dimension; legal range 2..7.
REQ-002 Parameter IW, default 3, SHALL set the index width of all select and index outputs.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  in  1  SHALL request one full N x N multiply; sampled only in IDLE.
REQ-006 abort  in  1  SHALL synchronously cancel a run in progress.
REQ-007 mux_select1  out  IW  SHALL be the k index selecting element A[row][k].
REQ-008 mux_select2  out  IW  SHALL be the k index selecting element B[k][col].
REQ-009 row_idx  out  IW  SHALL be the current result row i.
REQ-010 col_idx  out  IW  SHALL be the current result column j.
REQ-011 acc_clr  out  1  SHALL clear the MAC accumulator.
REQ-012 acc_en  out  1  SHALL enable one accumulate of A[i][k]*B[k][j].
REQ-013 output_set  out  1  SHALL write the accumulator to result C[row_idx][col_idx].
REQ-014 output_clr  out  1  SHALL clear the result output register on abort.
REQ-015 mem_clr  out  1  SHALL clear the result memory before a run.
REQ-016 busy  out  1  SHALL be high in every state except IDLE.
REQ-017 done  out  1  SHALL pulse high for one cycle on normal completion.

Function
REQ-018 The FSM SHALL have the states IDLE, MCLR, ACLR, MAC, WRITE and FIN; all outputs SHALL be registered.
REQ-019 IDLE: if start=1 -> MCLR; otherwise stay in IDLE; i, j and k SHALL be held at 0.
REQ-020 MCLR: mem_clr=1 for exactly 1 cycle; then -> ACLR with i=0, j=0.
REQ-021 ACLR: acc_clr=1 for 1 cycle; k=0; then -> MAC.
REQ-022 MAC: acc_en=1 and mux_select1=mux_select2=k; k increments each cycle from 0 to N-1; after k=N-1 -> WRITE.
REQ-023 WRITE: output_set=1 for 1 cycle with the current row_idx/col_idx; then if j<N-1, j+1 and -> ACLR; else if i<N-1, j=0, i+1 and -> ACLR; else -> FIN.
REQ-024 FIN: done=1 for 1 cycle, busy=1; then -> IDLE with i, j and k cleared.
REQ-025 Order SHALL be row-major: j is the inner loop and i is the outer loop.
REQ-026 Per-element cost SHALL be N+2 cycles; the run from the first MCLR cycle to the FIN cycle inclusive SHALL take 2+N*N*(N+2) cycles (47 for N=3).
REQ-027 Outside MAC, acc_en=0 and mux_select1=mux_select2=0; acc_clr, acc_en, output_set and mem_clr SHALL be mutually exclusive.
REQ-028 start SHALL be ignored while busy=1; no queuing.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with output_clr=1 for that 1 cycle and done=0; abort in IDLE SHALL have no effect.
REQ-030 If abort and start are both high in IDLE, start SHALL win (abort ignored).
REQ-031 abort SHALL take priority over every other transition in non-IDLE states, including WRITE and FIN.
REQ-032 Index counters SHALL never exceed N-1; no wrap-around beyond N-1 is permitted.

Reset
REQ-033 While reset=0, the FSM SHALL be in IDLE and all outputs SHALL be 0, asynchronously, including when reset is asserted mid-run.
REQ-034 After reset deasserts, the block SHALL wait in IDLE for start; partial results are not resumed.

Verification
REQ-035 Reset then a 1-cycle start pulse with N=3 -> mem_clr 1 cycle, then 9 x (acc_clr, 3 x acc_en with k=0,1,2, output_set); done at cycle 47; busy is high for 47 cycles.
REQ-036 Track output_set positions -> (row_idx,col_idx) sequence is (0,0),(0,1),(0,2),(1,0)...(2,2), each exactly once.
REQ-037 Assert abort during MAC of element (1,1), k=1 -> next cycle IDLE, output_clr=1, done never asserts, busy=0.
REQ-038 Pulse start again at cycle 10 of a run -> ignored; exactly one done pulse, at cycle 47.
REQ-039 Drive reset=0 asynchronously during WRITE -> all outputs 0 immediately; after release, a new start gives a full 47-cycle run.
REQ-040 Set N=2 -> 4 elements x 4 cycles + 2 = 18 cycles; k never exceeds 1.
